// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO pointer/flag controller for the fifo_mem storage block.
// Define FIFO_ERR_STICKY_EN to make overflow/underflow sticky until wrst.
module fifo_sync_ctrl #(
  parameter int ASIZE    = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  output logic             wen,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE-1:0] raddr,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [ASIZE:0] ONE  = {{ASIZE{1'b0}}, 1'b1};
  localparam logic [ASIZE:0] AF_L = (ASIZE+1)'(AF_LEVEL);
  localparam logic [ASIZE:0] AE_L = (ASIZE+1)'(AE_LEVEL);

  logic [ASIZE:0] wptr, rptr;
  logic           push_ok, pop_ok, ov_ev, uf_ev;

  assign waddr = wptr[ASIZE-1:0];
  assign raddr = rptr[ASIZE-1:0];

  // Extra pointer bit distinguishes full from empty when the addresses match.
  assign empty        = (wptr == rptr);
  assign full         = (wptr[ASIZE] != rptr[ASIZE]) &&
                        (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);
  assign count        = wptr - rptr;
  assign almost_full  = (count >= AF_L);
  assign almost_empty = (count <= AE_L);

  // A pop frees the slot in the same cycle, so a full FIFO still takes push+pop.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;
  assign wen     = push_ok & ~wrst & ~clear;

  // Requests dropped by clear are not errors.
  assign ov_ev = push & ~push_ok & ~clear;
  assign uf_ev = pop & ~pop_ok & ~clear;

  always_ff @(posedge wclk) begin
    if (wrst || clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + ONE;
      if (pop_ok)  rptr <= rptr + ONE;
    end
  end

`ifdef FIFO_ERR_STICKY_EN
  always_ff @(posedge wclk) begin
    if (wrst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow | ov_ev;
      underflow <= underflow | uf_ev;
    end
  end
`else
  always_ff @(posedge wclk) begin
    if (wrst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ov_ev;
      underflow <= uf_ev;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Directed + random bench for fifo_sync_ctrl against a queue-based occupancy model.
module tb_fifo_sync_ctrl;
  localparam int ASIZE = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;

  logic             wclk = 1'b0;
  logic             wrst, clear, push, pop;
  logic             wen, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [ASIZE-1:0] waddr, raddr;
  logic [ASIZE:0]   count;

  int total = 0;
  int bad   = 0;

  // Model: queue of written slot addresses, free-running pointer indices.
  int   q[$];
  int   wi = 0, ri = 0;
  logic m_ov = 1'b0, m_uf = 1'b0;

  fifo_sync_ctrl #(.ASIZE(ASIZE), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .wclk(wclk), .wrst(wrst), .clear(clear), .push(push), .pop(pop),
    .wen(wen), .waddr(waddr), .raddr(raddr), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle: check pre-edge outputs against the model, then advance the model.
  task automatic cyc(input logic p, input logic o, input logic c, input logic r);
    int  n;
    bit  pa, pb;
    push = p; pop = o; clear = c; wrst = r;
    #1;
    n = q.size();
    chk("count", 32'(count), n);
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full",  32'(full),  32'(n == DEPTH));
    chk("almost_full",  32'(almost_full),  32'(n >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
    chk("overflow",  32'(overflow),  32'(m_ov));
    chk("underflow", 32'(underflow), 32'(m_uf));
    chk("waddr", 32'(waddr), wi % DEPTH);
    chk("raddr", 32'(raddr), (n > 0) ? q[0] : (ri % DEPTH));
    pa = p && (n < DEPTH || o);
    pb = o && n > 0;
    chk("wen", 32'(wen), 32'(pa && !c && !r));
    @(posedge wclk);
    if (r) begin
      q.delete(); wi = 0; ri = 0; m_ov = 0; m_uf = 0;
    end else if (c) begin
      q.delete(); wi = 0; ri = 0;
`ifndef FIFO_ERR_STICKY_EN
      m_ov = 0; m_uf = 0;
`endif
    end else begin
      if (pb) begin void'(q.pop_front()); ri = (ri + 1) % (2*DEPTH); end
      if (pa) begin q.push_back(wi % DEPTH); wi = (wi + 1) % (2*DEPTH); end
`ifdef FIFO_ERR_STICKY_EN
      m_ov = m_ov | (p && !pa);
      m_uf = m_uf | (o && !pb);
`else
      m_ov = p && !pa;
      m_uf = o && !pb;
`endif
    end
    @(negedge wclk);
  endtask

  initial begin
    wrst = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0;
    @(negedge wclk);
    @(negedge wclk);
    // 1: reset then idle (first cycle runs in reset with unknown model-free state skipped)
    cyc(0, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 0);
    // 2: fill, overflow push, drain in order
    repeat (16) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (16) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    // 3: full with simultaneous push & pop
    repeat (16) cyc(1, 0, 0, 0);
    repeat (5) cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    // 4: empty with push & pop, then pop
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    // 5: push 7, clear with push (dropped, not flagged)
    repeat (7) cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(0, 0, 0, 0);
    // clear on a full FIFO with push must not flag overflow
    repeat (16) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    cyc(0, 0, 0, 0);
    // 6: underflow then idle; sticky vs pulse decided by the model
    cyc(0, 1, 0, 0);
    repeat (10) cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    // random traffic with pointer wrap, rare clears and a mid-run reset
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 45),
          1'($urandom_range(0, 99) < 2), 1'(i == 150));
    end
    for (int i = 0; i < 60; i++) begin
      cyc(1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 65), 1'b0, 1'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_sync_ctrl.md
Name: fifo_sync_ctrl

Overview:
Single-clock FIFO controller that sequences the team's fifo_mem storage block, which has a combinational read and a write registered on wclk.
- Owns the write/read pointers and produces wen, waddr and raddr for the storage.
- Produces full/empty, almost-full/almost-empty and occupancy status, plus overflow/underflow error reporting.
- Sits between a producer issuing push and a consumer issuing pop. Read data comes from the storage at raddr; it is not routed through this block.

Parameters:
- ASIZE, 4, address width; depth DEPTH = 2^ASIZE entries.
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL (legal range 1..DEPTH).
- AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL (legal range 0..DEPTH-1).

Ports:
- wclk  in  1  sole clock, rising edge.
- wrst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush; empties the FIFO, error flags untouched.
- push  in  1  producer write request; data is presented to the storage by the producer.
- pop  in  1  consumer read request; consumer samples the storage read data in the same cycle.
- wen  out  1  storage write enable.
- waddr  out  ASIZE  storage write address.
- raddr  out  ASIZE  storage read address.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ASIZE+1  occupancy, 0..DEPTH.
- overflow  out  1  push rejected because FIFO full.
- underflow  out  1  pop rejected because FIFO empty.

Behaviour:
- One clock (wclk); reset wrst is synchronous and active-high. Reset and clear are sampled only on the rising edge of wclk.
- Pointers:
  - wptr and rptr are ASIZE+1 bits wide; waddr = wptr[ASIZE-1:0], raddr = rptr[ASIZE-1:0].
  - Both wrap naturally modulo 2^(ASIZE+1).
- Status flags and count are all combinational from the registered pointers, so they update in the cycle after the accepting edge:
  - empty = (wptr == rptr).
  - full = (MSBs differ) and (low ASIZE bits equal).
  - count = wptr - rptr, modulo 2^(ASIZE+1).
- Values on reset: wptr = rptr = 0, so empty=1, full=0, count=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0), overflow=0, underflow=0.
- Acceptance, evaluated combinationally in the current cycle:
  - push_ok = push & (~full | pop).
  - pop_ok = pop & ~empty.
  - wen = push_ok & ~wrst & ~clear.
- Pointer update on the clock edge:
  - If push_ok, wptr increments; if pop_ok, rptr increments; both may increment in the same edge.
- Simultaneous events:
  - Full with push & pop: both are accepted and count stays at DEPTH. The storage write to waddr == raddr lands after the edge; the consumer has already sampled the old data.
  - Empty with push & pop: push is accepted, pop is rejected and flagged as underflow; count becomes 1.
- Rejections:
  - push & ~push_ok: no pointer change, wen=0, overflow asserts.
  - pop & ~pop_ok: no pointer change, underflow asserts.
- Priority order: wrst > clear > push/pop.
  - clear zeroes both pointers and forces wen=0.
  - A push or pop in the same cycle as clear is discarded and is not flagged.
  - Reset mid-operation zeroes everything on the next edge, whatever traffic is present.
- Latency:
  - A push accepted at edge N can be popped in the cycle after edge N.
  - empty deasserts in the cycle after the first push.

Optional Feature:
- Macro: FIFO_ERR_STICKY_EN.
- Defined:
  - overflow and underflow are sticky registers.
  - They set on the edge following a rejected request and hold until wrst.
  - clear does not reset them.
- Undefined:
  - overflow and underflow are single-cycle registered pulses, asserted in the cycle after each rejected request.
  - They return to 0 otherwise.
- Pointer and flag behaviour is identical in both builds.

Test Plan:
1. Reset then idle -> empty=1, full=0, count=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, wen=0.
2. ASIZE=4: 16 consecutive pushes, then a 17th push; then 16 pops checking raddr 0..15.
   - After 12 pushes: almost_full=1.
   - After 16 pushes: full=1, count=16.
   - 17th push: wen=0, overflow=1, count stays 16.
   - Pops: returned data order matches write order; empty=1 at end.
3. Fill to 16, then hold push & pop together for 5 cycles -> full stays 1, count=16, waddr and raddr advance together, wen=1 each cycle.
4. From empty, push & pop in the same cycle -> count=1, underflow=1, rptr unchanged; then pop -> empty=1.
5. Push 7, then clear together with push -> next cycle count=0, empty=1; the discarded push did not write (wen=0).
6. With FIFO_ERR_STICKY_EN defined: underflow event followed by 10 idle cycles -> underflow stays 1 until wrst. Without the macro: a 1-cycle pulse only. Also cover 40 push/pop cycles to exercise pointer wrap past 31 -> count stays consistent.
